// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD host: FSM state encoding and default sizing.
package gcd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int TMO_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/gcd_host_timer.sv
// WAIT-state watchdog for the GCD host: counts enabled cycles from a clear and
// flags expiry on the TIMEOUT_CYC-th cycle, then saturates instead of wrapping.
module gcd_host_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYC = TMO_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_host.sv
// Initiator for the GCD core START/DONE/ERROR handshake, bridging operand and result streams.
// Define GCD_HOST_ZCHK_EN to reject zero operands locally without issuing them to the core.
module gcd_host
  import gcd_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TMO_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_A,
  input  logic [DATA_W-1:0] IN_B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_Y,
  output logic              OUT_ERR,
  output logic              OUT_TMO,
  output logic              GCD_START,
  output logic [DATA_W-1:0] GCD_A,
  output logic [DATA_W-1:0] GCD_B,
  input  logic [DATA_W-1:0] GCD_Y,
  input  logic              GCD_DONE,
  input  logic              GCD_ERROR
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic              start_q, start_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              expire;

  gcd_host_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (state_q == ISSUE),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = vld_q;
  assign OUT_Y     = y_q;
  assign OUT_ERR   = err_q;
  assign OUT_TMO   = tmo_q;
  assign GCD_START = start_q;
  assign GCD_A     = a_q;
  assign GCD_B     = b_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = 1'b0;
    vld_d   = vld_q;
    y_d     = y_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
`ifdef GCD_HOST_ZCHK_EN
          if (IN_A == '0 || IN_B == '0) begin
            state_d = HOLD;
            vld_d   = 1'b1;
            y_d     = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b0;
          end else
`endif
          begin
            a_d     = IN_A;
            b_d     = IN_B;
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // DONE takes priority over a timeout expiring in the same cycle.
        if (GCD_DONE) begin
          y_d     = GCD_ERROR ? '0 : GCD_Y;
          err_d   = GCD_ERROR;
          tmo_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else if (expire) begin
          y_d     = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (vld_q && OUT_READY) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host: vector table, hand sequences and random jobs against a reference GCD model.
module tb_gcd_host;

  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int NEVER = -100;
`ifdef GCD_HOST_ZCHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [DW-1:0] IN_A, IN_B, OUT_Y, GCD_A, GCD_B, GCD_Y;
  logic          OUT_ERR, OUT_TMO, GCD_START, GCD_DONE, GCD_ERROR;

  always #5 CLK = ~CLK;

  gcd_host #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Y(OUT_Y),
    .OUT_ERR(OUT_ERR), .OUT_TMO(OUT_TMO),
    .GCD_START(GCD_START), .GCD_A(GCD_A), .GCD_B(GCD_B),
    .GCD_Y(GCD_Y), .GCD_DONE(GCD_DONE), .GCD_ERROR(GCD_ERROR)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a, b;
    int            dly, hold, late;
    logic [DW-1:0] ey;
    bit            eerr, etmo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return DW'(x);
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // dly: DONE is driven dly cycles into WAIT (negative -> never in WAIT; -1 -> during ISSUE).
  task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] b, input int dly,
                         input int hold, input int late, input logic [DW-1:0] ey,
                         input bit eerr, input bit etmo, input string tag);
    int  starts, start_k, kv, exp_kv, exp_starts;
    bit  zerr, seen, ops_ok, stable_ok;
    zerr = (a == 0) || (b == 0);
    if (ZCHK && zerr) begin
      exp_kv = 0; exp_starts = 0;
    end else if (etmo) begin
      exp_kv = TMO + 1; exp_starts = 1;
    end else begin
      exp_kv = dly + 2; exp_starts = 1;
    end
    chk({tag, " in_ready_idle"}, IN_READY, 1);
    IN_A = a; IN_B = b; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; IN_A = DW'($urandom); IN_B = DW'($urandom);
    starts = 0; start_k = -1; kv = -1; seen = 0; ops_ok = 1;
    for (int k = 0; k < TMO + 20; k++) begin
      if (OUT_VALID) begin kv = k; seen = 1; break; end
      if (GCD_START) begin starts++; if (start_k < 0) start_k = k; end
      if ({GCD_A, GCD_B} !== {a, b}) ops_ok = 0;
      if (k == dly + 1) begin
        GCD_DONE = 1'b1; GCD_ERROR = zerr;
        GCD_Y = zerr ? 8'hA5 : ref_gcd(a, b);
      end
      tick();
      GCD_DONE = 1'b0; GCD_ERROR = 1'b0; GCD_Y = DW'($urandom);
    end
    chk({tag, " valid_seen"}, seen, 1);
    chk({tag, " latency"}, kv, exp_kv);
    chk({tag, " start_count"}, starts, exp_starts);
    if (exp_starts == 1) begin
      chk({tag, " start_cycle"}, start_k, 0);
      chk({tag, " ops_held"}, ops_ok, 1);
    end
    chk({tag, " y"}, OUT_Y, ey);
    chk({tag, " err"}, OUT_ERR, eerr);
    chk({tag, " tmo"}, OUT_TMO, etmo);
    OUT_READY = 1'b0;
    stable_ok = 1;
    for (int h = 0; h < hold; h++) begin
      if (h == late) begin GCD_DONE = 1'b1; GCD_Y = 8'h3C; GCD_ERROR = 1'b0; end
      tick();
      GCD_DONE = 1'b0;
      if (!OUT_VALID || OUT_Y !== ey || OUT_ERR !== eerr || OUT_TMO !== etmo || IN_READY)
        stable_ok = 0;
    end
    if (hold > 0) chk({tag, " hold_stable"}, stable_ok, 1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, " released_valid"}, OUT_VALID, 0);
    chk({tag, " released_ready"}, IN_READY, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra, rb, rey;
    int            rdly;
    bit            rerr, rtmo;

    RST = 1'b1; IN_VALID = 0; IN_A = 0; IN_B = 0; OUT_READY = 0;
    GCD_Y = 0; GCD_DONE = 0; GCD_ERROR = 0;
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst in_ready", IN_READY, 1);
    chk("rst out_valid", OUT_VALID, 0);
    chk("rst start", GCD_START, 0);
    chk("rst gcd_ab", {GCD_A, GCD_B}, 0);
    chk("rst out_y", OUT_Y, 0);
    chk("rst err_tmo", {OUT_ERR, OUT_TMO}, 0);

    // Stale DONE while idle must be ignored.
    GCD_DONE = 1'b1; GCD_Y = 8'h11;
    tick();
    GCD_DONE = 1'b0;
    tick();
    chk("stale_done valid", OUT_VALID, 0);
    chk("stale_done ready", IN_READY, 1);

    vecs[0]  = '{a:12,  b:18,  dly:4,       hold:0,  late:-1, ey:6,  eerr:0, etmo:0};
    vecs[1]  = '{a:0,   b:5,   dly:3,       hold:0,  late:-1, ey:0,  eerr:1, etmo:0};
    vecs[2]  = '{a:30,  b:45,  dly:NEVER,   hold:5,  late:2,  ey:0,  eerr:0, etmo:1};
    vecs[3]  = '{a:7,   b:21,  dly:2,       hold:10, late:-1, ey:7,  eerr:0, etmo:0};
    vecs[4]  = '{a:9,   b:18,  dly:TMO-1,   hold:0,  late:-1, ey:9,  eerr:0, etmo:0};
    vecs[5]  = '{a:9,   b:27,  dly:TMO,     hold:1,  late:-1, ey:0,  eerr:0, etmo:1};
    vecs[6]  = '{a:13,  b:0,   dly:0,       hold:0,  late:-1, ey:0,  eerr:1, etmo:0};
    vecs[7]  = '{a:100, b:75,  dly:0,       hold:2,  late:-1, ey:25, eerr:0, etmo:0};
    vecs[8]  = '{a:1,   b:255, dly:1,       hold:0,  late:-1, ey:1,  eerr:0, etmo:0};
    vecs[9]  = '{a:40,  b:60,  dly:-1,      hold:0,  late:-1, ey:0,  eerr:0, etmo:1};
    vecs[10] = '{a:255, b:85,  dly:5,       hold:0,  late:-1, ey:85, eerr:0, etmo:0};
    vecs[11] = '{a:0,   b:0,   dly:2,       hold:3,  late:1,  ey:0,  eerr:1, etmo:0};

    for (int i = 0; i < 12; i++)
      run_job(vecs[i].a, vecs[i].b, vecs[i].dly, vecs[i].hold, vecs[i].late,
              vecs[i].ey, vecs[i].eerr, vecs[i].etmo, $sformatf("vec%0d", i));

    // Reset pulsed while the job is waiting on the core.
    IN_A = 50; IN_B = 20; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick(); tick(); tick();
    #2 RST = 1'b1;
    #1;
    chk("midrst start", GCD_START, 0);
    chk("midrst gcd_ab", {GCD_A, GCD_B}, 0);
    chk("midrst outs", {OUT_VALID, OUT_Y, OUT_ERR, OUT_TMO}, 0);
    chk("midrst in_ready", IN_READY, 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    GCD_DONE = 1'b1; GCD_Y = 8'd10;
    tick();
    GCD_DONE = 1'b0;
    tick();
    chk("midrst no_result", OUT_VALID, 0);
    run_job(255, 85, 3, 0, -1, 85, 0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 8'd0 : DW'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : DW'($urandom);
      rdly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TMO - 2, TMO + 1))
                                         : int'($urandom_range(0, 8));
      rerr = (ra == 0) || (rb == 0);
      if (rerr && (ZCHK || rdly <= TMO - 1)) begin
        rey = 0; rtmo = 0;
      end else if (rdly > TMO - 1) begin
        rey = 0; rerr = 0; rtmo = 1;
      end else begin
        rey = ref_gcd(ra, rb); rtmo = 0;
      end
      run_job(ra, rb, rdly, int'($urandom_range(0, 3)), -1, rey, rerr, rtmo,
              $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
